// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path (and the matching receiver).
// State encodings are plain 3-bit constants so older tools and netlists agree on them.
package uart_pkg;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE          = 3'd0;
  localparam tx_state_t ST_START         = 3'd1;
  localparam tx_state_t ST_DATA          = 3'd2;
  localparam tx_state_t ST_PARITY        = 3'd3;
  localparam tx_state_t ST_STOP          = 3'd4;
  localparam tx_state_t ST_BREAK_RECOVER = 3'd5;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Clocks per bit period; integer division, no half-period rounding.
  function automatic int unsigned calc_bit_cycles(input int unsigned clk_hz,
                                                  input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 and pulses tick on the last count.
// restart forces the count back to 0 on the next edge so a frame starts on a clean period.
module uart_baud_tick #(
  parameter int unsigned BIT_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: wrap on tick or when the owner restarts the period.
  always_comb begin
    tick = (cnt_q == LAST);
    if (restart || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (data width, parity, stop bits) with valid/ready intake.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN, which adds
// the tx_break input and the break-recovery state.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 16_000_000,
  parameter int unsigned BAUD        = 9_600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 CLR,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 data_out
);

  localparam int unsigned BIT_CYCLES = calc_bit_cycles(CLK_HZ, BAUD);
  localparam int unsigned IDX_W      = $clog2(DATA_BITS);

  if (BIT_CYCLES < 2) begin : g_bad_baud
    $error("uart_tx_cfg: CLK_HZ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD)
  begin : g_bad_parity
    $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 data_out_q, data_out_d;
  logic                 tick, restart, accept, last_stop;

  // Period counter is held at 0 while idle and restarted on every accepted byte.
  assign restart = (state_q == ST_IDLE) || accept;

  uart_baud_tick #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (CLR),
    .restart(restart),
    .tick   (tick)
  );

  // idx doubles as the stop-bit counter while in STOP.
  assign last_stop = (idx_q == IDX_W'(STOP_BITS - 1));

  // Ready depends only on state and the period counter, never on tx_valid.
  always_comb begin
    tx_ready = 1'b0;
    if (state_q == ST_IDLE) begin
`ifdef UART_TX_BREAK_EN
      // Low data_out while idle means a break is still on the line.
      tx_ready = !tx_break && data_out_q;
`else
      tx_ready = 1'b1;
`endif
    end else if (state_q == ST_STOP && last_stop && tick) begin
      tx_ready = 1'b1;
    end
  end

  assign accept   = tx_valid && tx_ready;
  assign tx_busy  = (state_q != ST_IDLE);
  assign data_out = data_out_q;

  // Frame sequencing; a byte is latched together with its parity on accept.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          shift_d = tx_data;
          par_d   = (PARITY_MODE == PAR_EVEN) ? ^tx_data : ~^tx_data;
          idx_d   = '0;
        end
`ifdef UART_TX_BREAK_EN
        else if (!tx_break && !data_out_q) begin
          state_d = ST_BREAK_RECOVER;
        end
`endif
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (last_stop) begin
            idx_d = '0;
            if (accept) begin
              // Back-to-back frame: next start bit follows with no idle gap.
              state_d = ST_START;
              shift_d = tx_data;
              par_d   = (PARITY_MODE == PAR_EVEN) ? ^tx_data : ~^tx_data;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK_RECOVER: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Line value for the upcoming cycle, derived from the next state so the output is registered.
  always_comb begin
    case (state_d)
      ST_START:  data_out_d = 1'b0;
      ST_DATA:   data_out_d = shift_d[0];
      ST_PARITY: data_out_d = par_d;
`ifdef UART_TX_BREAK_EN
      ST_IDLE:   data_out_d = !tx_break;
`endif
      default:   data_out_d = 1'b1;
    endcase
  end

  // State registers; reset forces the line high immediately.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      data_out_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three configurations at 10 clocks per bit.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       CLR = 1'b1;
  logic [2:0] valid_r = '0;
  logic [8:0] data_r [3];
  logic [2:0] line_w, ready_w, busy_w;
`ifdef UART_TX_BREAK_EN
  logic       brk_r = 1'b0;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  // 8N1
  uart_tx_cfg #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)
  ) u0 (
    .clk     (clk),
    .CLR     (CLR),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk_r),
`endif
    .tx_valid(valid_r[0]),
    .tx_data (data_r[0][7:0]),
    .tx_ready(ready_w[0]),
    .tx_busy (busy_w[0]),
    .data_out(line_w[0])
  );

  // 7E2
  uart_tx_cfg #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)
  ) u1 (
    .clk     (clk),
    .CLR     (CLR),
`ifdef UART_TX_BREAK_EN
    .tx_break(1'b0),
`endif
    .tx_valid(valid_r[1]),
    .tx_data (data_r[1][6:0]),
    .tx_ready(ready_w[1]),
    .tx_busy (busy_w[1]),
    .data_out(line_w[1])
  );

  // 8O1
  uart_tx_cfg #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)
  ) u2 (
    .clk     (clk),
    .CLR     (CLR),
`ifdef UART_TX_BREAK_EN
    .tx_break(1'b0),
`endif
    .tx_valid(valid_r[2]),
    .tx_data (data_r[2][7:0]),
    .tx_ready(ready_w[2]),
    .tx_busy (busy_w[2]),
    .data_out(line_w[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int idx, input string tag);
    check({tag, " line"},  {31'd0, line_w[idx]},  32'd1);
    check({tag, " ready"}, {31'd0, ready_w[idx]}, 32'd1);
    check({tag, " busy"},  {31'd0, busy_w[idx]},  32'd0);
  endtask

  // Called one step after the accept edge; pat[i] is the i-th bit on the line.
  task automatic run_frame(input int idx, input logic [15:0] pat, input int n,
                           input string tag);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 10; c++) begin
        check($sformatf("%s b%0d c%0d line", tag, b, c), {31'd0, line_w[idx]}, {31'd0, pat[b]});
        check($sformatf("%s b%0d c%0d ready", tag, b, c), {31'd0, ready_w[idx]},
              (b == n - 1 && c == 9) ? 32'd1 : 32'd0);
        check($sformatf("%s b%0d c%0d busy", tag, b, c), {31'd0, busy_w[idx]}, 32'd1);
        tick_step();
      end
    end
  endtask

  task automatic send(input int idx, input logic [8:0] d);
    valid_r[idx] = 1'b1;
    data_r[idx]  = d;
    tick_step();
    valid_r[idx] = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) data_r[i] = '0;
    #12;
    for (int i = 0; i < 3; i++) check_idle(i, $sformatf("reset u%0d", i));
    CLR = 1'b0;
    tick_step();

    // 8N1 0xA5
    send(0, 9'h0A5);
    run_frame(0, {1'b1, 8'hA5, 1'b0}, 10, "t1_a5");
    check_idle(0, "t1_after");

    // 7E2 0x41: even parity 0, two stop bits; data changed after accept must not matter
    send(1, 9'h041);
    data_r[1] = 9'h07F;
    run_frame(1, {2'b11, 1'b0, 7'h41, 1'b0}, 11, "t2_41");
    check_idle(1, "t2_after");

    // 8O1 0x41 and 0x00: odd parity 1 in both
    send(2, 9'h041);
    run_frame(2, {1'b1, 1'b1, 8'h41, 1'b0}, 11, "t3_41");
    check_idle(2, "t3a_after");
    send(2, 9'h000);
    run_frame(2, {1'b1, 1'b1, 8'h00, 1'b0}, 11, "t3_00");
    check_idle(2, "t3b_after");

    // Back-to-back 0x55 then 0x0F with valid held high
    valid_r[0] = 1'b1;
    data_r[0]  = 9'h055;
    tick_step();
    data_r[0]  = 9'h00F;
    run_frame(0, {1'b1, 8'h55, 1'b0}, 10, "t4_55");
    valid_r[0] = 1'b0;
    run_frame(0, {1'b1, 8'h0F, 1'b0}, 10, "t4_0f");
    check_idle(0, "t4_after");

    // Reset at clock 37 of a 0x5A frame (data bit 2 = 0 on the line)
    send(0, 9'h05A);
    repeat (37) tick_step();
    check("t5 pre line", {31'd0, line_w[0]}, 32'd0);
    check("t5 pre busy", {31'd0, busy_w[0]}, 32'd1);
    #1;
    CLR = 1'b1;
    #1;
    check_idle(0, "t5_clr");
    #2;
    CLR = 1'b0;
    tick_step();
    check_idle(0, "t5_rel");
    send(0, 9'h0C3);
    run_frame(0, {1'b1, 8'hC3, 1'b0}, 10, "t5_c3");
    check_idle(0, "t5_after");

`ifdef UART_TX_BREAK_EN
    // Break for 50 clocks, then one bit period of recovery
    brk_r = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick_step();
      check($sformatf("t6 brk %0d line", i), {31'd0, line_w[0]}, 32'd0);
      check($sformatf("t6 brk %0d ready", i), {31'd0, ready_w[0]}, 32'd0);
    end
    brk_r = 1'b0;
    check("t6 drop ready", {31'd0, ready_w[0]}, 32'd0);
    for (int j = 1; j <= 10; j++) begin
      tick_step();
      check($sformatf("t6 rec %0d line", j), {31'd0, line_w[0]}, 32'd1);
      check($sformatf("t6 rec %0d ready", j), {31'd0, ready_w[0]}, 32'd0);
    end
    tick_step();
    check_idle(0, "t6_after");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
